fb_arbiter: RTL and testbench



---
 rtl/fb_arb_pkg.sv | 19 +
 rtl/fb_rd_return_pipe.sv | 47 ++++
 rtl/fb_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer arbiter: default widths, guard FSM
// state encoding and the registered memory command layout.
package fb_arb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 12;

  typedef enum logic {
    RD_PRI   = 1'b0,
    WR_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic                 we;
    logic [FB_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/fb_rd_return_pipe.sv
// Read return pipeline: tracks accepted reads through the memory latency and
// captures mem_rdata into the registered rd_data/rd_data_valid outputs.
module fb_rd_return_pipe
  import fb_arb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tok_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid
);

  // Stage k is high in the cycle k+1 after acceptance; the last stage lines up
  // with the cycle in which mem_rdata holds the requested word.
  logic [RD_LAT:0]   vld_q, vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;

  always_comb begin
    vld_d           = {vld_q[RD_LAT-1:0], tok_in};
    rd_data_valid_d = vld_q[RD_LAT];
    rd_data_d       = rd_data_q;
    if (vld_q[RD_LAT]) begin
      rd_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q           <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      vld_q           <= vld_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: read-priority grant, registered memory
// command, fixed-latency read return. Optional write-starvation guard: FB_ARB_STARVE_GUARD_EN.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request transfers in the cycle where valid & ready are both
  // high; requesters hold addr/data stable until then. Ready never depends on
  // mem_rdata and both readies stay low while reset is high.
  logic wr_acc, rd_acc;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (!reset) begin
      if (state_q == WR_FORCE) begin
        wr_ready = wr_valid;
      end else begin
        rd_ready = rd_valid_in;
        wr_ready = wr_valid & ~rd_valid_in;
      end
    end
    case (state_q)
      RD_PRI: begin
        if (wr_valid && !wr_ready) begin
          if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
            state_d = WR_FORCE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      WR_FORCE: begin
        state_d = RD_PRI;
        cnt_d   = '0;
      end
      default: begin
        state_d = RD_PRI;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RD_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    rd_ready = ~reset & rd_valid_in;
    wr_ready = ~reset & wr_valid & ~rd_valid_in;
  end
`endif

  assign wr_acc = wr_valid & wr_ready;
  assign rd_acc = rd_valid_in & rd_ready;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (wr_acc) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = 1'b1;
    end else if (rd_acc) begin
      mem_addr_d = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

  fb_rd_return_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_return_pipe (
    .clk           (clk),
    .reset         (reset),
    .tok_in        (rd_acc),
    .mem_rdata     (mem_rdata),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 2-cycle synchronous memory model and a
// read-return scoreboard.
module tb_fb_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 12;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_valid_in = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  fb_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_valid_in   (rd_valid_in),
    .rd_addr       (rd_addr),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (read latency 2) ----------------
  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] mem_d1 = '0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_d1    <= mem[mem_addr[9:0]];
    mem_rdata <= mem_d1;
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d;
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (rd_data_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_data_valid=1 data=%h, required no return", rd_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (rd_data !== exp_d) begin
          n_fail++;
          $display("FAIL rd_data: got %h, required %h", rd_data, exp_d);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(int i);
    int v;
    v = i * 7 + 341;
    return v[DATA_W-1:0];
  endfunction

  task automatic drain_check(string name);
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    wr_valid = 1'b1; rd_valid_in = 1'b1;
    wr_addr = 17'h00001; rd_addr = 17'h00002; wr_data = 12'hFFF;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, wr_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_ready: rd/wr ready=%b, required 00", {rd_ready, wr_ready});
      end
    end
    step;
    wr_valid = 1'b0; rd_valid_in = 1'b0;
    n_checks++;
    if ({mem_addr, mem_we, mem_wdata, rd_data, rd_data_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h we=%b wdata=%h rd_data=%h rdv=%b, required all 0",
               mem_addr, mem_we, mem_wdata, rd_data, rd_data_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_only;
    step;
    wr_valid = 1'b1; wr_addr = 17'h00010; wr_data = 12'hABC;
    @(negedge clk);
    n_checks++;
    if ({rd_ready, wr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_ready: rd/wr ready=%b, required 01", {rd_ready, wr_ready});
    end
    step;
    wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'h00010, 12'hABC}) begin
      n_fail++;
      $display("FAIL write_cmd: we=%b addr=%h wdata=%h, required 1 00010 abc", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 17'h00010, 12'hABC}) begin
      n_fail++;
      $display("FAIL write_hold: we=%b addr=%h wdata=%h, required 0 00010 abc", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_read_back;
    int hit;
    hit = 0;
    step;
    rd_valid_in = 1'b1; rd_addr = 17'h00010;
    @(negedge clk);
    n_checks++;
    if ({rd_ready, wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_ready: rd/wr ready=%b, required 10", {rd_ready, wr_ready});
    end
    exp_q.push_back(12'hABC);
    step;
    rd_valid_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if ({mem_we, mem_addr} !== {1'b0, 17'h00010}) begin
          n_fail++;
          $display("FAIL read_cmd: we=%b addr=%h, required 0 00010", mem_we, mem_addr);
        end
      end
      if (rd_data_valid === 1'b1 && hit == 0) hit = k;
    end
    n_checks++;
    if (hit != 4) begin
      n_fail++;
      $display("FAIL read_latency: return after %0d cycles, required 4", hit);
    end
  endtask

  task automatic test_contention;
    step;
    wr_valid = 1'b1; wr_addr = 17'h00020; wr_data = 12'h123;
    rd_valid_in = 1'b1; rd_addr = 17'h00010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, wr_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL contention_ready%0d: rd/wr ready=%b, required 10", c, {rd_ready, wr_ready});
      end
      if (c > 0) begin
        n_checks++;
        if (mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL contention_we%0d: mem_we=%b, required 0", c, mem_we);
        end
      end
      exp_q.push_back(12'hABC);
      step;
    end
    rd_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_ready, wr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL contention_wr_ready: rd/wr ready=%b, required 01", {rd_ready, wr_ready});
    end
    step;
    wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'h00020, 12'h123}) begin
      n_fail++;
      $display("FAIL contention_wr_cmd: we=%b addr=%h wdata=%h, required 1 00020 123", mem_we, mem_addr, mem_wdata);
    end
    drain_check("contention");
  endtask

  task automatic test_same_addr;
    step;
    wr_valid = 1'b1; wr_addr = 17'h00010; wr_data = 12'h555;
    rd_valid_in = 1'b1; rd_addr = 17'h00010;
    @(negedge clk);
    n_checks++;
    if ({rd_ready, wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL same_addr_ready: rd/wr ready=%b, required 10", {rd_ready, wr_ready});
    end
    exp_q.push_back(12'hABC);
    step;
    rd_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_addr_wr_ready: wr_ready=%b, required 1", wr_ready);
    end
    step;
    wr_valid = 1'b0;
    rd_valid_in = 1'b1;
    @(negedge clk);
    exp_q.push_back(12'h555);
    step;
    rd_valid_in = 1'b0;
    drain_check("same_addr");
  endtask

  task automatic test_guard;
    step;
    wr_valid = 1'b1; wr_addr = 17'h00030; wr_data = 12'h777;
    rd_valid_in = 1'b1; rd_addr = 17'h00010;
`ifdef FB_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 10; c++) begin
      logic [1:0] exp_rw;
      exp_rw = (c == 9) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++;
      if ({rd_ready, wr_ready} !== exp_rw) begin
        n_fail++;
        $display("FAIL guard_cycle%0d: rd/wr ready=%b, required %b", c, {rd_ready, wr_ready}, exp_rw);
      end
      if (c != 9) exp_q.push_back(12'h555);
      step;
      if (c == 9) wr_valid = 1'b0;
    end
    rd_valid_in = 1'b0;
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, wr_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: rd/wr ready=%b, required 10", c, {rd_ready, wr_ready});
      end
      exp_q.push_back(12'h555);
      step;
    end
    rd_valid_in = 1'b0;
    step;
    wr_valid = 1'b0;
`endif
    drain_check("guard");
  endtask

  task automatic test_back_to_back;
    int n_ret, first, gaps;
    logic prev;
    n_ret = 0; first = -1; gaps = 0; prev = 1'b0;
    step;
    for (int i = 0; i < 640; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = pat(i);
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_wr_ready%0d: wr_ready=%b, required 1", i, wr_ready);
      end
      step;
    end
    wr_valid = 1'b0;
    step;
    for (int j = 0; j < 648; j++) begin
      rd_valid_in = (j < 640);
      rd_addr = ADDR_W'(j);
      @(negedge clk);
      if (j < 640) begin
        n_checks++;
        if (rd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rd_ready%0d: rd_ready=%b, required 1", j, rd_ready);
        end
        exp_q.push_back(pat(j));
      end
      if (rd_data_valid === 1'b1) begin
        n_ret++;
        if (first < 0) first = j;
        else if (!prev) gaps++;
      end
      prev = (rd_data_valid === 1'b1);
      step;
    end
    rd_valid_in = 1'b0;
    n_checks++;
    if (n_ret != 640 || gaps != 0 || first != 4) begin
      n_fail++;
      $display("FAIL b2b_stream: returns=%0d gaps=%0d first=%0d, required 640 0 4", n_ret, gaps, first);
    end
    drain_check("b2b");
  endtask

  task automatic test_reset_mid;
    step;
    rd_valid_in = 1'b1; rd_addr = 17'h00005;
    step;
    rd_addr = 17'h00006;
    step;
    reset = 1'b1; wr_valid = 1'b1; wr_addr = 17'h00007; wr_data = 12'h0F0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, wr_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_ready%0d: rd/wr ready=%b, required 00", c, {rd_ready, wr_ready});
      end
      step;
    end
    reset = 1'b0; rd_valid_in = 1'b0; wr_valid = 1'b0;
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_rd_data: rd_data=%h, required 000", rd_data);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_data_valid, mem_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_quiet%0d: rd_data_valid=%b mem_we=%b, required 0 0", c, rd_data_valid, mem_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_read_back();
    test_contention();
    test_same_addr();
    test_guard();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
